// File: rtl/fetch_inst_queue.sv
// Instruction queue between fetch and dual-issue decode: compacts valid lanes of a 4-wide
// fetch group into a circular buffer and presents up to two entries per cycle to decode.
module fiq_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic [27:0] pc_base,
  input  logic        jump,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [31:0] tgt
);
  assign pc  = {pc_base, LANE, 2'b00};
  assign tgt = jump ? next_pc : pc + 32'd4;
endmodule

module fetch_inst_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             fs_valid,
  output logic             fs_ready,
  input  logic [31:0]      fs_pc,
  input  logic [127:0]     fs_inst,
  input  logic [3:0]       fs_lane_valid,
  input  logic [3:0]       fs_lane_jump,
  input  logic [31:0]      fs_next_pc,
  input  logic [1:0]       ds_take,
  output logic [1:0]       ds_valid,
  output logic [31:0]      ds_pc0,
  output logic [31:0]      ds_pc1,
  output logic [31:0]      ds_inst0,
  output logic [31:0]      ds_inst1,
  output logic             ds_pred0,
  output logic             ds_pred1,
  output logic [31:0]      ds_tgt0,
  output logic [31:0]      ds_tgt1,
  output logic [PTR_W:0]   count
);
  localparam int NUM_LANES = 4;
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - NUM_LANES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic [31:0] tgt;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] head, tail, head1;
  logic [NUM_LANES-1:0][31:0]      lane_pc, lane_tgt;
  logic [NUM_LANES-1:0][PTR_W-1:0] wr_idx;
  logic [2:0] push_n;
  logic [1:0] pop_n;
  logic       push, take0, take1;
  logic       unused_pc_lo;

  assign unused_pc_lo = ^fs_pc[3:0];

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      fiq_lane #(.LANE(2'(k))) u_lane (
        .pc_base (fs_pc[31:4]),
        .jump    (fs_lane_jump[k]),
        .next_pc (fs_next_pc),
        .pc      (lane_pc[k]),
        .tgt     (lane_tgt[k])
      );
    end
  endgenerate

  // Lane k lands at tail + (number of valid lanes below k): lowest valid lane goes first.
  always_comb begin
    logic [PTR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_idx[i] = tail + acc;
      acc = acc + PTR_W'(fs_lane_valid[i]);
    end
  end

  assign push_n = 3'(fs_lane_valid[0]) + 3'(fs_lane_valid[1])
                + 3'(fs_lane_valid[2]) + 3'(fs_lane_valid[3]);
  assign fs_ready = (count <= READY_MAX);
  assign push     = fs_valid && fs_ready && !flush && !reset;

  assign ds_valid = {count >= (PTR_W+1)'(2), count != '0};
  assign take0    = ds_take[0] & ds_valid[0];
  assign take1    = ds_take[1] & ds_take[0] & ds_valid[1];
  assign pop_n    = {1'b0, take0} + {1'b0, take1};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(push_n);
      head  <= head + PTR_W'(pop_n);
      count <= count + (push ? (PTR_W+1)'(push_n) : '0) - (PTR_W+1)'(pop_n);
    end
  end

  // Storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (fs_lane_valid[i])
          mem[wr_idx[i]] <= '{pc: lane_pc[i], inst: fs_inst[32*i +: 32],
                              pred: fs_lane_jump[i], tgt: lane_tgt[i]};
      end
    end
  end

  assign head1    = head + PTR_W'(1);
  assign ds_pc0   = mem[head].pc;
  assign ds_inst0 = mem[head].inst;
  assign ds_pred0 = mem[head].pred;
  assign ds_tgt0  = mem[head].tgt;
  assign ds_pc1   = mem[head1].pc;
  assign ds_inst1 = mem[head1].inst;
  assign ds_pred1 = mem[head1].pred;
  assign ds_tgt1  = mem[head1].tgt;
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: stimulus queues expected entries, a monitor checks
// the decode ports against the queue head every cycle and retires popped entries.
module tb_fetch_inst_queue;
  logic         clk = 1'b0, reset = 1'b1, flush = 1'b0, fs_valid = 1'b0;
  logic         fs_ready;
  logic [31:0]  fs_pc = '0, fs_next_pc = '0;
  logic [127:0] fs_inst = '0;
  logic [3:0]   fs_lane_valid = '0, fs_lane_jump = '0;
  logic [1:0]   ds_take = '0, ds_valid;
  logic [31:0]  ds_pc0, ds_pc1, ds_inst0, ds_inst1, ds_tgt0, ds_tgt1;
  logic         ds_pred0, ds_pred1;
  logic [4:0]   count;

  fetch_inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fs_valid(fs_valid), .fs_ready(fs_ready),
    .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_lane_valid(fs_lane_valid),
    .fs_lane_jump(fs_lane_jump), .fs_next_pc(fs_next_pc), .ds_take(ds_take),
    .ds_valid(ds_valid), .ds_pc0(ds_pc0), .ds_pc1(ds_pc1), .ds_inst0(ds_inst0),
    .ds_inst1(ds_inst1), .ds_pred0(ds_pred0), .ds_pred1(ds_pred1), .ds_tgt0(ds_tgt0),
    .ds_tgt1(ds_tgt1), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0, n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(logic [31:0] pc, int k);
    return pc ^ 32'h5A5A_0000 ^ 32'(k);
  endfunction

  // Monitor: compare the decode view with the scoreboard, then retire what decode took.
  initial begin
    wait (mon_en);
    forever begin
      int sz, pn;
      bit fl;
      @(negedge clk);
      sz = q.size();
      if (!reset) begin
        chk("mon_count", 32'(count), 32'(sz));
        chk("mon_ds_valid", 32'(ds_valid), {30'd0, sz >= 2, sz >= 1});
        chk("mon_fs_ready", 32'(fs_ready), 32'(sz <= 12));
        if (sz >= 1) begin
          chk("mon_pc0", ds_pc0, q[0].pc);
          chk("mon_inst0", ds_inst0, q[0].inst);
          chk("mon_pred0", 32'(ds_pred0), 32'(q[0].pred));
          chk("mon_tgt0", ds_tgt0, q[0].tgt);
        end
        if (sz >= 2) begin
          chk("mon_pc1", ds_pc1, q[1].pc);
          chk("mon_inst1", ds_inst1, q[1].inst);
          chk("mon_pred1", 32'(ds_pred1), 32'(q[1].pred));
          chk("mon_tgt1", ds_tgt1, q[1].tgt);
        end
      end
      pn = (ds_take[0] && sz >= 1) + (ds_take[1] && ds_take[0] && sz >= 2);
      fl = reset || flush;
      @(posedge clk);
      if (fl) q.delete();
      else repeat (pn) void'(q.pop_front());
    end
  end

  // Drive one cycle of stimulus; queue the entries that this push should create.
  task automatic step(bit v, logic [31:0] pc, logic [3:0] lanes, logic [3:0] jmp,
                      logic [31:0] np, logic [1:0] tk, bit fl);
    ent_t pend[$];
    bit   fire;
    fs_valid = v; fs_pc = pc; fs_lane_valid = lanes; fs_lane_jump = jmp;
    fs_next_pc = np; ds_take = tk; flush = fl;
    for (int k = 0; k < 4; k++) fs_inst[32*k +: 32] = inst_of(pc, k);
    fire = v && (q.size() <= 12) && !fl && !reset;
    if (fire) begin
      for (int k = 0; k < 4; k++) begin
        if (lanes[k]) begin
          ent_t e;
          logic [1:0] kk;
          kk = 2'(k);
          e.pc   = {pc[31:4], kk, 2'b00};
          e.inst = inst_of(pc, k);
          e.pred = jmp[k];
          e.tgt  = jmp[k] ? np : e.pc + 32'd4;
          pend.push_back(e);
        end
      end
    end
    @(posedge clk);
    foreach (pend[i]) q.push_back(pend[i]);
    #1;
    fs_valid = 1'b0; fs_lane_valid = '0; fs_lane_jump = '0; ds_take = '0; flush = 1'b0;
  endtask

  task automatic idle(logic [1:0] tk);
    step(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, tk, 1'b0);
  endtask

  task automatic push(logic [31:0] pc, logic [3:0] lanes);
    step(1'b1, pc, lanes, 4'h0, 32'h0, 2'b00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ds_valid", 32'(ds_valid), 32'd0);
    chk("reset_fs_ready", 32'(fs_ready), 32'd1);

    // Full group, no jump.
    push(32'h1C00_0000, 4'b1111);
    chk("full_count", 32'(count), 32'd4);
    chk("full_pc0", ds_pc0, 32'h1C00_0000);
    chk("full_pc1", ds_pc1, 32'h1C00_0004);
    chk("full_tgt0", ds_tgt0, 32'h1C00_0004);
    idle(2'b11);
    idle(2'b11);

    // Partial groups and a predicted jump.
    push(32'h1C00_0018, 4'b1100);
    chk("part_pc0", ds_pc0, 32'h1C00_0018);
    chk("part_pc1", ds_pc1, 32'h1C00_001C);
    step(1'b1, 32'h1C00_0020, 4'b0011, 4'b0010, 32'h1C00_0100, 2'b00, 1'b0);
    chk("part_count", 32'(count), 32'd4);
    idle(2'b11);
    chk("jump_pc0", ds_pc0, 32'h1C00_0020);
    chk("jump_tgt0", ds_tgt0, 32'h1C00_0024);
    chk("jump_pc1", ds_pc1, 32'h1C00_0024);
    chk("jump_pred1", 32'(ds_pred1), 32'd1);
    chk("jump_tgt1", ds_tgt1, 32'h1C00_0100);
    idle(2'b11);
    chk("drain_count", 32'(count), 32'd0);

    // Fill to 13: further pushes are refused until decode drains.
    push(32'h1000_0000, 4'b1111);
    push(32'h1000_0010, 4'b1111);
    push(32'h1000_0020, 4'b1111);
    push(32'h1000_0030, 4'b0001);
    chk("fill_count", 32'(count), 32'd13);
    chk("fill_ready", 32'(fs_ready), 32'd0);
    push(32'h2000_0000, 4'b1111);
    push(32'h2000_0010, 4'b1111);
    chk("stall_count", 32'(count), 32'd13);
    idle(2'b11);
    chk("unstall_count", 32'(count), 32'd11);
    chk("unstall_ready", 32'(fs_ready), 32'd1);

    // Flush, then walk head to 14 and push a group straddling the wrap.
    step(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 2'b00, 1'b1);
    chk("flush1_count", 32'(count), 32'd0);
    push(32'h3000_0000, 4'b1111);
    push(32'h3000_0010, 4'b1111);
    push(32'h3000_0020, 4'b1111);
    repeat (6) idle(2'b11);
    push(32'h3000_0030, 4'b0011);
    idle(2'b11);
    push(32'h4000_0000, 4'b1111);
    chk("wrap_count4", 32'(count), 32'd4);
    chk("wrap_pc0_h14", ds_pc0, 32'h4000_0000);
    chk("wrap_pc1_h15", ds_pc1, 32'h4000_0004);
    step(1'b1, 32'h4000_0010, 4'b1111, 4'h0, 32'h0, 2'b11, 1'b0);
    chk("wrap_count6", 32'(count), 32'd6);
    chk("wrap_pc0_h0", ds_pc0, 32'h4000_0008);
    chk("wrap_pc1_h1", ds_pc1, 32'h4000_000C);
    idle(2'b01);

    // Flush beats a simultaneous push and pop.
    push(32'h5000_0000, 4'b0111);
    push(32'h5000_0010, 4'b0001);
    chk("preflush_count", 32'(count), 32'd9);
    step(1'b1, 32'h6000_0000, 4'b1111, 4'b1111, 32'h6666_0000, 2'b11, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_ds_valid", 32'(ds_valid), 32'd0);
    chk("flush_ready", 32'(fs_ready), 32'd1);
    step(1'b1, 32'h7000_0000, 4'b0110, 4'b1111, 32'h7777_0000, 2'b00, 1'b0);
    chk("multi_jump_pc0", ds_pc0, 32'h7000_0004);
    chk("multi_jump_tgt0", ds_tgt0, 32'h7777_0000);
    chk("multi_jump_pred1", 32'(ds_pred1), 32'd1);

    // Take 11 with one entry pops one; take 10 never pops.
    idle(2'b01);
    idle(2'b11);
    chk("single_pop_count", 32'(count), 32'd0);
    push(32'h8000_0000, 4'b1011);
    idle(2'b10);
    chk("take10_count", 32'(count), 32'd3);
    idle(2'b11);
    idle(2'b11);
    chk("tail_drain_count", 32'(count), 32'd0);

    // Reset mid-operation clears like flush.
    push(32'h9000_0000, 4'b1111);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_ready", 32'(fs_ready), 32'd1);
    step(1'b1, 32'hA000_0000, 4'b0101, 4'b0100, 32'hABCD_0000, 2'b00, 1'b0);
    chk("post_reset_pc1", ds_pc1, 32'hA000_0008);
    idle(2'b11);
    chk("final_count", 32'(count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
